// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller.
// The optional lap freeze is enabled by defining STOPWATCH_LAP_EN.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } sw_state_e;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  localparam logic [4*BCD_W-1:0] COUNT_MAX = 16'h9999;
  localparam logic [4*BCD_W-1:0] COUNT_MIN = 16'h0000;

  // Any nibble above 9 saturates to 9, so 16'hFA3C becomes 16'h9939.
  function automatic logic [4*BCD_W-1:0] clamp_preset(input logic [4*BCD_W-1:0] p);
    logic [4*BCD_W-1:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[i*BCD_W +: BCD_W] = (p[i*BCD_W +: BCD_W] > BCD_MAX) ? BCD_MAX : p[i*BCD_W +: BCD_W];
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit (0..9) with load, up/down step and a carry/borrow output
// that enables the next more significant digit.
module bcd_digit_counter
  import stopwatch_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             ld_i,
  input  logic [BCD_W-1:0] ld_val_i,
  output logic [BCD_W-1:0] q_o,
  output logic [BCD_W-1:0] next_o,
  output logic             co_o
);

  logic [BCD_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (ld_i) begin
      q_d = ld_val_i;
    end else if (en_i) begin
      if (up_i) q_d = (q_q == BCD_MAX) ? '0 : q_q + 4'd1;
      else      q_d = (q_q == '0) ? BCD_MAX : q_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign co_o   = en_i & (up_i ? (q_q == BCD_MAX) : (q_q == '0));
  assign q_o    = q_q;
  assign next_o = q_d;

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch/timer sequencer: FSM, 100 Hz prescaler, mode latch and a 4-digit
// BCD count SS.cc. Lap display freeze is built only with STOPWATCH_LAP_EN.
module stopwatch_controller
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        load,
  input  logic        lap,
  input  logic        mode_down,
  input  logic [15:0] preset,
  output logic [3:0]  dig0,
  output logic [3:0]  dig1,
  output logic [3:0]  dig2,
  output logic [3:0]  dig3,
  output logic        running,
  output logic        done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  sw_state_e state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic mode_q, mode_d;

  logic tick;
  logic cnt_ld;
  logic [4*BCD_W-1:0] cnt_ld_val;
  logic [4*BCD_W-1:0] count_q;
  logic [4*BCD_W-1:0] count_next;
  logic [3:0] dig_en;
  logic [3:0] dig_co;
  logic limit_hit;
  logic unused_carry;

  assign tick = (state_q == ST_RUN) && (presc_q == PRESC_LAST);

  // Direction is fixed by mode_q, which only tracks mode_down while idle.
  assign limit_hit = tick && (mode_q ? (count_next == COUNT_MIN) : (count_next == COUNT_MAX));

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    mode_d     = mode_q;
    cnt_ld     = 1'b0;
    cnt_ld_val = clamp_preset(preset);
    if (state_q == ST_IDLE) mode_d = mode_down;
    if (clear) begin
      state_d    = ST_IDLE;
      presc_d    = '0;
      cnt_ld     = 1'b1;
      cnt_ld_val = mode_q ? clamp_preset(preset) : COUNT_MIN;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_stop)  state_d = (mode_q && count_q == COUNT_MIN) ? ST_DONE : ST_RUN;
          else if (load)   cnt_ld  = 1'b1;
        end
        ST_RUN: begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (limit_hit)       state_d = ST_DONE;
          else if (start_stop) state_d = ST_PAUSE;
        end
        ST_PAUSE: begin
          if (start_stop) state_d = ST_RUN;
          else if (load)  cnt_ld  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      mode_q  <= mode_d;
    end
  end

  assign dig_en[0] = tick;
  assign dig_en[1] = dig_co[0];
  assign dig_en[2] = dig_co[1];
  assign dig_en[3] = dig_co[2];
  assign unused_carry = dig_co[3];

  for (genvar g = 0; g < 4; g++) begin : g_digit
    bcd_digit_counter u_digit (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_i     (dig_en[g]),
      .up_i     (!mode_q),
      .ld_i     (cnt_ld),
      .ld_val_i (cnt_ld_val[g*BCD_W +: BCD_W]),
      .q_o      (count_q[g*BCD_W +: BCD_W]),
      .next_o   (count_next[g*BCD_W +: BCD_W]),
      .co_o     (dig_co[g])
    );
  end

  logic [4*BCD_W-1:0] disp;

`ifdef STOPWATCH_LAP_EN
  logic frz_q, frz_d;
  logic [4*BCD_W-1:0] lap_val_q, lap_val_d;

  // Any exit from RUN (pause, done, clear) releases the freeze.
  always_comb begin
    frz_d     = frz_q;
    lap_val_d = lap_val_q;
    if (state_d != ST_RUN || clear) begin
      frz_d = 1'b0;
    end else if (state_q == ST_RUN && lap) begin
      frz_d = !frz_q;
      if (!frz_q) lap_val_d = count_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frz_q     <= 1'b0;
      lap_val_q <= '0;
    end else begin
      frz_q     <= frz_d;
      lap_val_q <= lap_val_d;
    end
  end

  assign disp = frz_q ? lap_val_q : count_q;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign disp = count_q;
`endif

  assign dig0    = disp[3:0];
  assign dig1    = disp[7:4];
  assign dig2    = disp[11:8];
  assign dig3    = disp[15:12];
  assign running = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);

endmodule
